pipe_hazard_ctrl: RTL and testbench

Pipeline scheduler for the 5-stage MIPS core (F/D/X/M/W). It tracks in-flight register writes in a shadow scoreboard and stalls F/D on read-after-write hazards, because the core has no forwarding paths. It also squashes younger instructions when a branch or jump redirects in X. Its outputs drive the PC enable, the F->D register enable, and the flush/bubble controls of the F->D and D->X registers.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/hz_scoreboard.sv | 56 +++++
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard control slice:
// scheduler states, shadow scoreboard entries and the match helper.
package mips_pkg;

    // Widest register index a shadow slot can hold.
    localparam int MAX_REG_ADDR_W = 8;

    localparam logic [MAX_REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        HZ_RUN,
        HZ_FLUSH
    } t_hz_state;

    typedef struct packed {
        logic                      v;
        logic [MAX_REG_ADDR_W-1:0] dst;
    } t_sb_entry;

    function automatic logic sbHit(
        input t_sb_entry                 e,
        input logic [MAX_REG_ADDR_W-1:0] rs,
        input logic [MAX_REG_ADDR_W-1:0] rt,
        input logic                      usesRs,
        input logic                      usesRt
    );
        logic live;
        live = e.v & (e.dst != REG_ZERO);
        return live & ((usesRs & (rs == e.dst))
                     | (usesRt & (rt == e.dst)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D/X-stage view of the pipeline seen by the hazard controller,
// plus the enables, flush controls and counters it returns.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_regwrite;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  ex_redirect;
    logic                  pc_en;
    logic                  fd_en;
    logic                  flush_fd;
    logic                  dx_bubble;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt,
        output id_uses_rs, id_uses_rt,
        output id_regwrite, id_dst, ex_redirect,
        input  pc_en, fd_en, flush_fd, dx_bubble,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt,
        input  id_uses_rs, id_uses_rt,
        input  id_regwrite, id_dst, ex_redirect,
        output pc_en, fd_en, flush_fd, dx_bubble,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hz_scoreboard.sv
// Shadow X/M/W pipe of pending register writes and the
// per-slot RAW match vector against the D-stage sources.
module hz_scoreboard
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dWrite,
    input  logic [REG_ADDR_W-1:0] dDst,
    input  logic                  bubble,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  usesRs,
    input  logic                  usesRt,
    output logic [2:0]            matchVec
);

    t_sb_entry slotX;
    t_sb_entry slotM;
    t_sb_entry slotW;
    t_sb_entry dEntry;

    logic [MAX_REG_ADDR_W-1:0] rsExt;
    logic [MAX_REG_ADDR_W-1:0] rtExt;

    assign rsExt = MAX_REG_ADDR_W'(rs);
    assign rtExt = MAX_REG_ADDR_W'(rt);

    always_comb begin
        dEntry.dst = MAX_REG_ADDR_W'(dDst);
        dEntry.v   = dWrite & ~bubble
                   & (dEntry.dst != REG_ZERO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotX <= '0;
            slotM <= '0;
            slotW <= '0;
        end else begin
            slotX <= dEntry;
            slotM <= slotX;
            slotW <= slotM;
        end
    end

    assign matchVec[0] = sbHit(slotX, rsExt, rtExt,
                               usesRs, usesRt);
    assign matchVec[1] = sbHit(slotM, rsExt, rtExt,
                               usesRs, usesRt);
    assign matchVec[2] = sbHit(slotW, rsExt, rtExt,
                               usesRs, usesRt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the forwarding-less 5-stage core:
// RAW stalls from the shadow scoreboard, squash after X redirects.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int WB_BYPASS    = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES);
    localparam logic W_STALLS = (WB_BYPASS == 0);

    t_hz_state        state;
    t_hz_state        stateNext;
    logic [1:0]       fc;
    logic [1:0]       fcNext;
    logic [2:0]       matchVec;
    logic             hazard;
    logic             stall;
    logic             squash;
    logic             dWrite;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    assign dWrite = hz.id_valid & hz.id_regwrite
                  & ~stall & ~squash;

    hz_scoreboard #(
        .REG_ADDR_W(REG_ADDR_W)
    ) uScoreboard (
        .clk      (clk),
        .rst      (rst),
        .dWrite   (dWrite),
        .dDst     (hz.id_dst),
        .bubble   (stall | squash),
        .rs       (hz.id_rs),
        .rt       (hz.id_rt),
        .usesRs   (hz.id_uses_rs),
        .usesRt   (hz.id_uses_rt),
        .matchVec (matchVec)
    );

    // A W-slot match is harmless when the regfile bypasses W data.
    assign hazard = matchVec[0] | matchVec[1]
                  | (matchVec[2] & W_STALLS);
    assign squash = hz.ex_redirect | (state == HZ_FLUSH);
    assign stall  = hz.id_valid & ~squash & hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
            fc    <= '0;
        end else begin
            state <= stateNext;
            fc    <= fcNext;
        end
    end

    always_comb begin
        stateNext = state;
        fcNext    = fc;
        unique case (state)
            HZ_RUN: begin
                if (hz.ex_redirect && FC_LOAD != 2'd0) begin
                    stateNext = HZ_FLUSH;
                    fcNext    = FC_LOAD;
                end
            end
            HZ_FLUSH: begin
                if (hz.ex_redirect) begin
                    fcNext = FC_LOAD;
                end else if (fc == 2'd1) begin
                    stateNext = HZ_RUN;
                    fcNext    = 2'd0;
                end else begin
                    fcNext = fc - 2'd1;
                end
            end
            default: begin
                stateNext = HZ_RUN;
                fcNext    = 2'd0;
            end
        endcase
    end

    // Held in reset the pipe is frozen with NOPs in F/D and D/X.
    always_comb begin
        hz.pc_en     = 1'b0;
        hz.fd_en     = 1'b0;
        hz.flush_fd  = 1'b1;
        hz.dx_bubble = 1'b1;
        if (!rst) begin
            hz.pc_en     = ~stall | squash;
            hz.fd_en     = ~stall | squash;
            hz.flush_fd  = squash;
            hz.dx_bubble = stall | squash;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall && stallCnt != '1)
                stallCnt <= stallCnt + CNT_W'(1);
            if (hz.ex_redirect && flushCnt != '1)
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stallCnt;
    assign hz.flush_cnt = flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two configurations driven in
// lockstep, checked every cycle against a register-age model.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          idValid;
    logic [AW-1:0] idRs;
    logic [AW-1:0] idRt;
    logic          idUsesRs;
    logic          idUsesRt;
    logic          idRegwrite;
    logic [AW-1:0] idDst;
    logic          exRedirect;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(16)) busA ();
    pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(2))  busB ();

    assign busA.id_valid    = idValid;
    assign busA.id_rs       = idRs;
    assign busA.id_rt       = idRt;
    assign busA.id_uses_rs  = idUsesRs;
    assign busA.id_uses_rt  = idUsesRt;
    assign busA.id_regwrite = idRegwrite;
    assign busA.id_dst      = idDst;
    assign busA.ex_redirect = exRedirect;
    assign busB.id_valid    = idValid;
    assign busB.id_rs       = idRs;
    assign busB.id_rt       = idRt;
    assign busB.id_uses_rs  = idUsesRs;
    assign busB.id_uses_rt  = idUsesRt;
    assign busB.id_regwrite = idRegwrite;
    assign busB.id_dst      = idDst;
    assign busB.ex_redirect = exRedirect;

    // A: no W bypass, one flush cycle, 16-bit counters.
    pipe_hazard_ctrl #(
        .REG_ADDR_W(AW), .WB_BYPASS(0),
        .FLUSH_CYCLES(1), .CNT_W(16)
    ) dutA (.clk(clk), .rst(rst), .hz(busA));

    // B: W bypass, two flush cycles, 2-bit counters saturate fast.
    pipe_hazard_ctrl #(
        .REG_ADDR_W(AW), .WB_BYPASS(1),
        .FLUSH_CYCLES(2), .CNT_W(2)
    ) dutB (.clk(clk), .rst(rst), .hz(busB));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d",
                     name, act, exp);
        end
    endtask

    // Model: a register is unreadable until its last issued
    // writer is more than depthOf() cycles old.
    int lastIss [2][32];
    int flushLeft [2];
    int stallN [2];
    int flushN [2];
    int now = 0;

    function automatic int depthOf(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int fcOf(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int satOf(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic bit pend(input int k, input logic [AW-1:0] r);
        return (r != 0) && ((now - lastIss[k][r]) <= depthOf(k));
    endfunction

    logic [3:0] got;
    logic [3:0] expCtl;
    int         gotSc;
    int         gotFc;
    int         expSc;
    int         expFc;
    logic       sq;
    logic       st;
    string      tag;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            tag = (k == 0) ? "A" : "B";
            if (k == 0) begin
                got = {busA.pc_en, busA.fd_en,
                       busA.flush_fd, busA.dx_bubble};
                gotSc = int'(busA.stall_cnt);
                gotFc = int'(busA.flush_cnt);
            end else begin
                got = {busB.pc_en, busB.fd_en,
                       busB.flush_fd, busB.dx_bubble};
                gotSc = int'(busB.stall_cnt);
                gotFc = int'(busB.flush_cnt);
            end
            sq = 1'b0;
            st = 1'b0;
            if (rst) begin
                expCtl = 4'b0011;
                expSc  = 0;
                expFc  = 0;
            end else begin
                sq = exRedirect || (flushLeft[k] > 0);
                st = idValid && !sq
                   && ((idUsesRs && pend(k, idRs))
                    || (idUsesRt && pend(k, idRt)));
                expCtl = {!st || sq, !st || sq, sq, st || sq};
                expSc  = stallN[k];
                expFc  = flushN[k];
            end
            chk({"ctl", tag}, int'(got), int'(expCtl));
            chk({"stallCnt", tag}, gotSc, expSc);
            chk({"flushCnt", tag}, gotFc, expFc);
            if (rst) begin
                for (int r = 0; r < 32; r++) lastIss[k][r] = -100;
                flushLeft[k] = 0;
                stallN[k]    = 0;
                flushN[k]    = 0;
            end else begin
                if (idValid && idRegwrite && idDst != 0
                    && !st && !sq)
                    lastIss[k][idDst] = now;
                if (exRedirect)
                    flushLeft[k] = fcOf(k);
                else if (flushLeft[k] > 0)
                    flushLeft[k]--;
                if (st && stallN[k] < satOf(k))
                    stallN[k]++;
                if (exRedirect && flushN[k] < satOf(k))
                    flushN[k]++;
            end
        end
        now++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idValid    = 1'b0;
        idRs       = '0;
        idRt       = '0;
        idUsesRs   = 1'b0;
        idUsesRt   = 1'b0;
        idRegwrite = 1'b0;
        idDst      = '0;
        exRedirect = 1'b0;
    endtask

    task automatic put(input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt,
                       input logic urs, input logic urt,
                       input logic rw,
                       input logic [AW-1:0] dst);
        idValid    = 1'b1;
        idRs       = rs;
        idRt       = rt;
        idUsesRs   = urs;
        idUsesRt   = urt;
        idRegwrite = rw;
        idDst      = dst;
        exRedirect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) cyc();
        #1;
        chk("rstPcEn", int'(busA.pc_en), 0);
        chk("rstBubble", int'(busA.dx_bubble), 1);
        chk("rstFlushFd", int'(busA.flush_fd), 1);
        cyc();
        rst = 1'b0;
        #1;
        chk("relPcEn", int'(busA.pc_en), 1);
        chk("relBubble", int'(busA.dx_bubble), 0);
        chk("relStallCnt", int'(busA.stall_cnt), 0);

        // add $3 then sub reading $3 right behind it
        cyc(); put(5'd1, 5'd2, 1, 1, 1, 5'd3);
        cyc(); put(5'd3, 5'd4, 1, 1, 1, 5'd5);
        #1;
        chk("rawPcEnA", int'(busA.pc_en), 0);
        chk("rawBubbleA", int'(busA.dx_bubble), 1);
        chk("rawPcEnB", int'(busB.pc_en), 0);
        cyc();
        cyc();
        #1;
        chk("wStallA", int'(busA.dx_bubble), 1);
        chk("wBypassB", int'(busB.dx_bubble), 0);
        cyc();
        #1;
        chk("rawDoneA", int'(busA.dx_bubble), 0);
        cyc(); idle();
        #1;
        chk("rawCntA", int'(busA.stall_cnt), 3);
        chk("rawCntB", int'(busB.stall_cnt), 2);
        repeat (4) cyc();

        // writes to $0 never create a dependency
        cyc(); put(5'd1, 5'd2, 1, 1, 1, 5'd0);
        cyc(); put(5'd0, 5'd0, 1, 1, 1, 5'd6);
        #1;
        chk("zeroBubbleA", int'(busA.dx_bubble), 0);
        cyc(); idle();
        #1;
        chk("zeroCntA", int'(busA.stall_cnt), 3);
        repeat (4) cyc();

        // redirect in the same cycle as a RAW stall
        cyc(); put(5'd1, 5'd2, 1, 1, 1, 5'd7);
        cyc(); put(5'd7, 5'd0, 1, 0, 1, 5'd8);
        exRedirect = 1'b1;
        #1;
        chk("rvsFlushA", int'(busA.flush_fd), 1);
        chk("rvsBubbleA", int'(busA.dx_bubble), 1);
        chk("rvsPcEnA", int'(busA.pc_en), 1);
        cyc(); idle();
        #1;
        chk("rvsHoldA", int'(busA.flush_fd), 1);
        cyc();
        #1;
        chk("rvsRunA", int'(busA.flush_fd), 0);
        chk("rvsHoldB", int'(busB.flush_fd), 1);
        cyc();
        #1;
        chk("rvsRunB", int'(busB.flush_fd), 0);
        chk("rvsFlushCntA", int'(busA.flush_cnt), 1);
        chk("rvsStallCntA", int'(busA.stall_cnt), 3);
        repeat (3) cyc();

        // back-to-back redirects
        cyc(); exRedirect = 1'b1;
        cyc(); exRedirect = 1'b1;
        cyc(); exRedirect = 1'b0;
        #1;
        chk("b2bHoldA", int'(busA.flush_fd), 1);
        cyc();
        #1;
        chk("b2bRunA", int'(busA.flush_fd), 0);
        chk("b2bHoldB", int'(busB.flush_fd), 1);
        cyc();
        #1;
        chk("b2bRunB", int'(busB.flush_fd), 0);
        chk("b2bCntA", int'(busA.flush_cnt), 3);
        chk("b2bCntB", int'(busB.flush_cnt), 3);
        cyc(); exRedirect = 1'b1;
        cyc(); exRedirect = 1'b0;
        #1;
        chk("flushSatB", int'(busB.flush_cnt), 3);
        chk("flushCntA", int'(busA.flush_cnt), 4);
        repeat (3) cyc();

        // second RAW pair drives B's stall counter into saturation
        cyc(); put(5'd1, 5'd2, 1, 1, 1, 5'd10);
        cyc(); put(5'd0, 5'd10, 0, 1, 1, 5'd11);
        repeat (3) cyc();
        cyc(); idle();
        #1;
        chk("stallCntA", int'(busA.stall_cnt), 6);
        chk("stallSatB", int'(busB.stall_cnt), 3);
        repeat (3) cyc();

        // async reset in the middle of a stall
        cyc(); put(5'd1, 5'd2, 1, 1, 1, 5'd12);
        cyc(); put(5'd12, 5'd0, 1, 0, 0, 5'd0);
        #1;
        chk("midStallA", int'(busA.dx_bubble), 1);
        #1 rst = 1'b1;
        #1;
        chk("asyncPcEnA", int'(busA.pc_en), 0);
        chk("asyncCntA", int'(busA.stall_cnt), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("postStallA", int'(busA.dx_bubble), 0);
        chk("postStallB", int'(busB.dx_bubble), 0);

        // async reset in the middle of a flush window
        cyc(); idle();
        cyc(); exRedirect = 1'b1;
        cyc(); exRedirect = 1'b0;
        #1;
        chk("midFlushA", int'(busA.flush_fd), 1);
        chk("midFlushPcA", int'(busA.pc_en), 1);
        #1 rst = 1'b1;
        #1;
        chk("asyncFlushPcA", int'(busA.pc_en), 0);
        chk("asyncFdEnA", int'(busA.fd_en), 0);
        chk("asyncBubbleA", int'(busA.dx_bubble), 1);
        chk("asyncFlushCntA", int'(busA.flush_cnt), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("noSquashA", int'(busA.flush_fd), 0);
        chk("noSquashB", int'(busB.flush_fd), 0);
        chk("noSquashPcA", int'(busA.pc_en), 1);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
